// File: rtl/dtc_pkg.sv
// Shared constants and types for the decision-tree classifier feature path.
package dtc_pkg;

  localparam int NIB_W     = 4;
  localparam int BEATS     = 3;
  localparam int FEAT_W    = NIB_W * BEATS;
  // Widest sequence tag any instance may use; narrower tags are zero-extended in the FIFO.
  localparam int SEQ_MAX_W = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } dtc_state_e;

  typedef struct packed {
    logic [FEAT_W-1:0]    feat;
    logic [SEQ_MAX_W-1:0] seq;
  } dtc_entry_t;

endpackage

// File: rtl/dtc_fifo2.sv
// Two-entry in-order FIFO of assembled feature vectors; head entry is read straight from registers.
module dtc_fifo2
  import dtc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  dtc_entry_t entry_i,
  input  logic       pop_i,
  output dtc_entry_t head_o,
  output logic [1:0] count_o
);

  dtc_entry_t mem_q [2];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= entry_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/dtc_feature_assembler.sv
// Assembles NIB_W-bit beats into FEAT_W-bit feature vectors, tags them with a sequence number
// and buffers up to two of them for the classifier.
module dtc_feature_assembler
  import dtc_pkg::*;
#(
  parameter int SEQ_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NIB_W-1:0]  in_data,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FEAT_W-1:0] out_feat,
  output logic [SEQ_W-1:0]  out_seq,
  output logic              err_sync,
  output dtc_state_e        dbg_state,
  output logic [1:0]        dbg_fifo_count
);

  // Handshakes: a beat/vector moves on a rising edge where valid & ready are both high; valid never
  // waits on ready, and in_ready depends only on registered FIFO occupancy.

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  dtc_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FEAT_W-1:0] asm_q, asm_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              err_q, err_d;
  logic              push;
  logic              accept;
  logic [1:0]        fifo_count;
  dtc_entry_t        push_entry;
  dtc_entry_t        head;

  assign in_ready = (fifo_count != 2'd2);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    seq_d   = seq_q;
    err_d   = 1'b0;
    push    = 1'b0;
    if (accept) begin
      if (in_sof) begin
        // A start-of-frame always restarts assembly; if one was in progress it is a framing error.
        err_d = (state_q == COLLECT);
        asm_d = FEAT_W'(in_data);
        if (BEATS == 1) begin
          push    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = COLLECT;
          cnt_d   = CNT_W'(1);
        end
      end else if (state_q == IDLE) begin
        err_d = 1'b1;
      end else begin
        asm_d[cnt_q*NIB_W +: NIB_W] = in_data;
        if (cnt_q == LAST_BEAT) begin
          push    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
    if (push) begin
      seq_d = seq_q + SEQ_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      seq_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
    end
  end

  assign push_entry.feat = asm_d;
  assign push_entry.seq  = SEQ_MAX_W'(seq_q);

  dtc_fifo2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (out_ready && out_valid),
    .head_o  (head),
    .count_o (fifo_count)
  );

  assign out_valid      = (fifo_count != 2'd0);
  assign out_feat       = head.feat;
  assign out_seq        = SEQ_W'(head.seq);
  assign err_sync       = err_q;
  assign dbg_state      = state_q;
  assign dbg_fifo_count = fifo_count;

endmodule

// File: tb/tb_dtc_feature_assembler.sv
// Bench for dtc_feature_assembler: directed scenarios with literal expectations plus a random
// phase, all checked every cycle against a queue-based model of framing and buffering.
module tb_dtc_feature_assembler;
  import dtc_pkg::*;

  localparam int SW = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [NIB_W-1:0]  in_data;
  logic              in_sof;
  logic              out_valid;
  logic              out_ready;
  logic [FEAT_W-1:0] out_feat;
  logic [SW-1:0]     out_seq;
  logic              err_sync;
  dtc_state_e        dbg_state;
  logic [1:0]        dbg_fifo_count;

  int checks;
  int failures;

  dtc_feature_assembler #(.SEQ_W(SW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_sof         (in_sof),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_feat       (out_feat),
    .out_seq        (out_seq),
    .err_sync       (err_sync),
    .dbg_state      (dbg_state),
    .dbg_fifo_count (dbg_fifo_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: beats of the frame in progress, vectors waiting downstream
  logic [NIB_W-1:0]       beats_q[$];
  logic [SW+FEAT_W-1:0]   exp_q[$];
  int                     m_seq;
  logic                   err_exp;
  bit                     live;

  initial begin
    logic s_rst, s_valid, s_sof, s_oready;
    logic [NIB_W-1:0]  s_data;
    logic [FEAT_W-1:0] feat;
    bit acc, pop;
    live    = 0;
    m_seq   = 0;
    err_exp = 0;
    forever begin
      @(posedge clk);
      s_rst    = rst;
      s_valid  = in_valid;
      s_sof    = in_sof;
      s_data   = in_data;
      s_oready = out_ready;
      if (s_rst) begin
        beats_q.delete();
        exp_q.delete();
        m_seq   = 0;
        err_exp = 0;
        live    = 1;
      end else if (live) begin
        acc     = s_valid && (exp_q.size() != 2);
        pop     = s_oready && (exp_q.size() != 0);
        err_exp = 0;
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
          if (s_sof) begin
            if (beats_q.size() != 0) err_exp = 1;
            beats_q.delete();
            beats_q.push_back(s_data);
          end else if (beats_q.size() == 0) begin
            err_exp = 1;
          end else begin
            beats_q.push_back(s_data);
          end
          if (beats_q.size() == BEATS) begin
            feat = '0;
            for (int k = 0; k < BEATS; k++) feat = feat | (FEAT_W'(beats_q[k]) << (k * NIB_W));
            exp_q.push_back({SW'(m_seq), feat});
            m_seq = (m_seq + 1) % (1 << SW);
            beats_q.delete();
          end
        end
      end
      #1;
      if (live) begin
        check("in_ready", 32'(in_ready), 32'(exp_q.size() != 2));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("fifo_count", 32'(dbg_fifo_count), 32'(exp_q.size()));
        check("err_sync", 32'(err_sync), 32'(err_exp));
        check("state", 32'(dbg_state), (beats_q.size() == 0) ? 32'(IDLE) : 32'(COLLECT));
        if (exp_q.size() != 0) begin
          check("out_feat", 32'(out_feat), 32'(exp_q[0][FEAT_W-1:0]));
          check("out_seq", 32'(out_seq), 32'(exp_q[0][SW+FEAT_W-1:FEAT_W]));
        end
      end
    end
  end

  // driver tasks: each starts and ends just after a falling edge
  task automatic send_beat(input logic [NIB_W-1:0] d, input logic sof);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    waited   = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("beat_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_vec(input logic [NIB_W-1:0] a, input logic [NIB_W-1:0] b,
                          input logic [NIB_W-1:0] c);
    send_beat(a, 1'b1);
    send_beat(b, 1'b0);
    send_beat(c, 1'b0);
  endtask

  initial begin
    int drv_pos;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_feat", 32'(out_feat), 32'd0);
    check("rst_out_seq", 32'(out_seq), 32'd0);
    check("rst_err_sync", 32'(err_sync), 32'd0);

    // basic assembly, LSB beat first
    send_vec(4'h5, 4'hA, 4'h3);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_feat", 32'(out_feat), 32'h3A5);
    check("t1_seq", 32'(out_seq), 32'd0);
    repeat (2) @(negedge clk);

    // backpressure: two stored, third waits for the first pop
    out_ready = 1'b0;
    send_vec(4'h1, 4'h2, 4'h3);
    send_vec(4'h4, 4'h5, 4'h6);
    check("t2_in_ready_full", 32'(in_ready), 32'd0);
    check("t2_count_full", 32'(dbg_fifo_count), 32'd2);
    check("t2_head_feat", 32'(out_feat), 32'h321);
    check("t2_head_seq", 32'(out_seq), 32'd1);
    out_ready = 1'b1;
    send_vec(4'h7, 4'h8, 4'h9);
    repeat (6) @(negedge clk);

    // restart mid-frame
    send_beat(4'h1, 1'b1);
    send_beat(4'h2, 1'b0);
    send_beat(4'h7, 1'b1);
    check("t3_err_pulse", 32'(err_sync), 32'd1);
    send_beat(4'h8, 1'b0);
    check("t3_err_single", 32'(err_sync), 32'd0);
    send_beat(4'h9, 1'b0);
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_feat", 32'(out_feat), 32'h987);
    repeat (3) @(negedge clk);

    // stray beat while idle
    send_beat(4'h4, 1'b0);
    check("t4_err_pulse", 32'(err_sync), 32'd1);
    check("t4_no_valid", 32'(out_valid), 32'd0);
    check("t4_idle", 32'(dbg_state), 32'(IDLE));

    // sequence tag wrap
    for (int v = 0; v < 17; v++)
      send_vec(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    repeat (3) @(negedge clk);

    // reset drops a partial vector and restarts the tag
    send_beat(4'h1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_vec(4'h5, 4'h6, 4'h7);
    check("t6_feat", 32'(out_feat), 32'h765);
    check("t6_seq", 32'(out_seq), 32'd0);
    repeat (2) @(negedge clk);

    // simultaneous push and pop at one entry
    out_ready = 1'b0;
    send_vec(4'h1, 4'h2, 4'h3);
    send_beat(4'h4, 1'b1);
    send_beat(4'h5, 1'b0);
    out_ready = 1'b1;
    send_beat(4'h6, 1'b0);
    check("t7_count", 32'(dbg_fifo_count), 32'd1);
    check("t7_feat", 32'(out_feat), 32'h654);
    repeat (2) @(negedge clk);

    // random traffic with backpressure, framing errors and occasional reset
    drv_pos = 0;
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 4'($urandom_range(0, 15));
      in_sof    = (drv_pos == 0) ^ ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (rst) drv_pos = 0;
      else if (in_valid && in_ready) drv_pos = in_sof ? 1 % BEATS : (drv_pos + 1) % BEATS;
      @(negedge clk);
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
